uart_phy_ext: RTL and testbench
===============================

UART_PHY_EXT -- requirements
Module: uart_phy_ext

Interface
REQ-001 SHALL have parameter clk_hz, default 100000000: input clock frequency in Hz.
REQ-002 SHALL have parameter baudrate, default 115200: line bit rate.
REQ-003 SHALL have parameter data_bits, default 8: data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter parity_mode, default 0: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter stop_bits, default 1: stop bits, legal values 1 or 2.
REQ-006 SHALL have port clk, input, 1: single clock; every register is on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port UART_TX, output, 1: serial transmit line, registered, idles high.
REQ-009 SHALL have port UART_RX, input, 1: asynchronous serial receive line.
REQ-010 SHALL have port tx_data, input, data_bits: byte to send.
REQ-011 SHALL have port tx_valid, input, 1: transmit request.
REQ-012 SHALL have port tx_ready, output, 1: transmitter idle and accepting.
REQ-013 SHALL have port rx_data, output, data_bits: last received data.
REQ-014 SHALL have port rx_valid, output, 1: one-cycle pulse, frame received.
REQ-015 SHALL have port rx_parity_err, output, 1: parity mismatch, qualified by rx_valid.
REQ-016 SHALL have port rx_frame_err, output, 1: first stop bit sampled low, qualified by rx_valid.
REQ-017 SHALL have port rx_break, output, 1: all data bits, parity bit and stop bit low, qualified by rx_valid.

Function
REQ-018 SHALL raise an elaboration error if clk_hz < baudrate*64, or if data_bits, parity_mode or stop_bits is outside its legal range.
REQ-019 SHALL generate a 16x oversample tick every os_div+1 clocks, where os_div = ((clk_hz + 8*baudrate)/(16*baudrate)) - 1; TX and RX each SHALL use an independent counter that is held at 0 while that side is idle.
REQ-020 SHALL make each bit exactly 16 ticks long; serial order SHALL be start(0), data LSB first, optional parity, then stop bit(s) at 1.
REQ-021 SHALL compute the parity bit as XOR of the data bits for even parity and its complement for odd parity.
REQ-022 SHALL run the TX FSM through IDLE -> START -> DATA -> PARITY (only when parity_mode != 0) -> STOP -> IDLE.
REQ-023 SHALL assert tx_ready only in TX IDLE; a transfer is accepted when tx_valid && tx_ready, and tx_data SHALL be captured on that cycle.
REQ-024 SHALL ignore tx_valid while TX is busy and SHALL not corrupt the in-flight frame.
REQ-025 SHALL drive the start bit on UART_TX in the cycle after acceptance.
REQ-026 SHALL reassert tx_ready in the cycle after the final stop-bit tick; back-to-back frames SHALL have no idle gap beyond that one cycle.
REQ-027 SHALL pass UART_RX through a 2-flop synchroniser reset to 1; a 1->0 transition of the synchronised line in RX IDLE SHALL start RX.
REQ-028 SHALL determine every RX bit by majority vote of the samples taken at ticks 7, 8 and 9 of that bit.
REQ-029 SHALL run the RX FSM through IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
REQ-030 SHALL return RX to IDLE with no output when the start bit votes 1 (false start).
REQ-031 SHALL pulse rx_valid for exactly one cycle at the first stop bit's vote, updating rx_data and all error flags in that same cycle.
REQ-032 SHALL return RX to IDLE immediately after that vote; a second stop bit is not checked, so resynchronisation is allowed mid-stop.
REQ-033 SHALL hold rx_data until the next rx_valid; the error flags SHALL be 0 whenever rx_valid is 0.
REQ-034 SHALL always report rx_parity_err = 0 when parity_mode = 0.
REQ-035 SHALL overwrite rx_data on each new frame with no buffering; the consumer SHALL capture it on the rx_valid cycle.
REQ-036 SHALL operate TX and RX fully concurrently, including loopback of UART_TX to UART_RX.

Reset
REQ-037 SHALL, on rst high at a clock edge, force both FSMs to IDLE and both tick counters to 0, set UART_TX=1, tx_ready=1, rx_valid=0, rx_data=0, all error flags 0, and synchroniser flops to 1.
REQ-038 SHALL apply REQ-037 when rst arrives mid-frame, so that UART_TX is 1 in the cycle after rst and the partial frame is discarded.
REQ-039 SHALL have valid power-up initial values equal to the reset values.

Verification (clk_hz=7372800, baudrate=115200: 4 clk/tick, 64 clk/bit)
REQ-040 SHALL be verified for 8N1 TX of 0xA5: UART_TX shows 0,1,0,1,0,0,1,0,1,1, each bit 64 cycles, and tx_ready stays low for 640 cycles.
REQ-041 SHALL be verified for 8E1 loopback of 0x37: rx_valid pulses once, rx_data=0x37, parity bit sent=1, and rx_parity_err=0.
REQ-042 SHALL be verified for 7O2 RX with the parity bit flipped: rx_parity_err=1, rx_frame_err=0, and rx_data matches the sent data.
REQ-043 SHALL be verified for a 20-cycle low glitch on UART_RX: no rx_valid, and RX is back in IDLE.
REQ-044 SHALL be verified for a 2-bit-time stop-bit-low frame of all zeros: rx_valid with rx_frame_err=1 and rx_break=1.
REQ-045 SHALL be verified for rst asserted at cycle 200 of a TX frame: UART_TX=1 and tx_ready=1 on the next cycle, and a new tx_valid then sends a clean frame.

Source files
------------

// File: rtl/uart_phy_ext.sv
// uart_phy_ext: UART transmitter and receiver sharing one clock, each with its
// own 16x oversample tick counter. Frames are start, LSB-first data, optional
// parity, then one or two stop bits. RX samples are majority-voted mid-bit.
module uart_phy_ext #(
  parameter int clk_hz      = 100000000,
  parameter int baudrate    = 115200,
  parameter int data_bits   = 8,
  parameter int parity_mode = 0,
  parameter int stop_bits   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 UART_TX,
  input  logic                 UART_RX,
  input  logic [data_bits-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [data_bits-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break
);

  localparam int OS_DIV = ((clk_hz + 8*baudrate) / (16*baudrate)) - 1;
  localparam int CW     = (OS_DIV > 0) ? $clog2(OS_DIV + 1) : 1;
  localparam logic [CW-1:0] OS_MAX    = CW'(OS_DIV);
  localparam logic [3:0]    LAST_DBIT = 4'(data_bits - 1);
  localparam logic          LAST_STOP = (stop_bits == 2);
  localparam logic          HAS_PAR   = (parity_mode != 0);
  localparam logic          ODD       = (parity_mode == 1);

  generate
    if (clk_hz < baudrate*64 || data_bits < 5 || data_bits > 9 ||
        parity_mode < 0 || parity_mode > 2 || (stop_bits != 1 && stop_bits != 2)) begin : g_bad_params
      $error("uart_phy_ext: illegal parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- transmitter ----------------
  state_t               tx_state_q = S_IDLE;
  state_t               tx_state_d;
  logic [CW-1:0]        tx_cnt_q   = '0;
  logic [CW-1:0]        tx_cnt_d;
  logic [3:0]           tx_sub_q   = '0;
  logic [3:0]           tx_sub_d;
  logic [3:0]           tx_bit_q   = '0;
  logic [3:0]           tx_bit_d;
  logic                 tx_stop_q  = 1'b0;
  logic                 tx_stop_d;
  logic [data_bits-1:0] tx_shift_q = '0;
  logic [data_bits-1:0] tx_shift_d;
  logic                 tx_par_q   = 1'b0;
  logic                 tx_par_d;
  logic                 tx_line_q  = 1'b1;
  logic                 tx_line_d;
  logic                 tx_tick;

  // TX next state: line value is registered, so each bit's level is loaded on
  // the edge that ends the previous bit (16th tick).
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_sub_d   = tx_sub_q;
    tx_bit_d   = tx_bit_q;
    tx_stop_d  = tx_stop_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_line_d  = tx_line_q;
    tx_tick    = 1'b0;
    if (tx_state_q == S_IDLE) begin
      tx_cnt_d  = '0;
      tx_sub_d  = '0;
      tx_line_d = 1'b1;
      if (tx_valid) begin
        tx_shift_d = tx_data;
        tx_par_d   = (^tx_data) ^ ODD;
        tx_line_d  = 1'b0;
        tx_state_d = S_START;
      end
    end else begin
      tx_tick  = (tx_cnt_q == OS_MAX);
      tx_cnt_d = tx_tick ? '0 : tx_cnt_q + CW'(1);
      if (tx_tick) tx_sub_d = tx_sub_q + 4'd1;
      if (tx_tick && tx_sub_q == 4'd15) begin
        case (tx_state_q)
          S_START: begin
            tx_state_d = S_DATA;
            tx_bit_d   = '0;
            tx_line_d  = tx_shift_q[0];
          end
          S_DATA: begin
            tx_shift_d = tx_shift_q >> 1;
            if (tx_bit_q == LAST_DBIT) begin
              if (HAS_PAR) begin
                tx_state_d = S_PARITY;
                tx_line_d  = tx_par_q;
              end else begin
                tx_state_d = S_STOP;
                tx_stop_d  = 1'b0;
                tx_line_d  = 1'b1;
              end
            end else begin
              tx_bit_d  = tx_bit_q + 4'd1;
              tx_line_d = tx_shift_q[1];
            end
          end
          S_PARITY: begin
            tx_state_d = S_STOP;
            tx_stop_d  = 1'b0;
            tx_line_d  = 1'b1;
          end
          S_STOP: begin
            if (tx_stop_q == LAST_STOP) tx_state_d = S_IDLE;
            else                        tx_stop_d  = 1'b1;
          end
          default: tx_state_d = S_IDLE;
        endcase
      end
    end
  end

  // TX state register
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_sub_q   <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_sub_q   <= tx_sub_d;
      tx_bit_q   <= tx_bit_d;
      tx_stop_q  <= tx_stop_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
    end
  end

  assign UART_TX  = tx_line_q;
  assign tx_ready = (tx_state_q == S_IDLE);

  // ---------------- receiver ----------------
  logic                 rx_s1_q    = 1'b1;
  logic                 rx_s1_d;
  logic                 rx_s2_q    = 1'b1;
  logic                 rx_s2_d;
  logic                 rx_prev_q  = 1'b1;
  logic                 rx_prev_d;
  state_t               rx_state_q = S_IDLE;
  state_t               rx_state_d;
  logic [CW-1:0]        rx_cnt_q   = '0;
  logic [CW-1:0]        rx_cnt_d;
  logic [3:0]           rx_sub_q   = '0;
  logic [3:0]           rx_sub_d;
  logic [3:0]           rx_bit_q   = '0;
  logic [3:0]           rx_bit_d;
  logic [1:0]           rx_smp_q   = '0;
  logic [1:0]           rx_smp_d;
  logic [data_bits-1:0] rx_shift_q = '0;
  logic [data_bits-1:0] rx_shift_d;
  logic                 rx_pbit_q  = 1'b0;
  logic                 rx_pbit_d;
  logic [data_bits-1:0] rx_data_q  = '0;
  logic [data_bits-1:0] rx_data_d;
  logic                 rx_valid_q = 1'b0;
  logic                 rx_valid_d;
  logic                 rx_pe_q    = 1'b0;
  logic                 rx_pe_d;
  logic                 rx_fe_q    = 1'b0;
  logic                 rx_fe_d;
  logic                 rx_brk_q   = 1'b0;
  logic                 rx_brk_d;
  logic                 rx_tick;
  logic                 rx_vote;

  // 2-of-3 vote: samples from ticks 7 and 8 plus the live sample at tick 9
  assign rx_vote = (rx_smp_q[0] & rx_smp_q[1]) | (rx_smp_q[0] & rx_s2_q) |
                   (rx_smp_q[1] & rx_s2_q);

  // RX next state: bit decisions happen at tick 9, state steps at tick 15;
  // the frame completes at the first stop-bit vote so a new start can follow.
  always_comb begin
    rx_s1_d    = UART_RX;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_sub_d   = rx_sub_q;
    rx_bit_d   = rx_bit_q;
    rx_smp_d   = rx_smp_q;
    rx_shift_d = rx_shift_q;
    rx_pbit_d  = rx_pbit_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_pe_d    = 1'b0;
    rx_fe_d    = 1'b0;
    rx_brk_d   = 1'b0;
    rx_tick    = 1'b0;
    if (rx_state_q == S_IDLE) begin
      rx_cnt_d = '0;
      rx_sub_d = '0;
      if (rx_prev_q && !rx_s2_q) rx_state_d = S_START;
    end else begin
      rx_tick  = (rx_cnt_q == OS_MAX);
      rx_cnt_d = rx_tick ? '0 : rx_cnt_q + CW'(1);
      if (rx_tick) rx_sub_d = rx_sub_q + 4'd1;
      if (rx_tick && rx_sub_q == 4'd7) rx_smp_d[0] = rx_s2_q;
      if (rx_tick && rx_sub_q == 4'd8) rx_smp_d[1] = rx_s2_q;
      if (rx_tick && rx_sub_q == 4'd9) begin
        case (rx_state_q)
          S_START: begin
            if (rx_vote) begin
              rx_state_d = S_IDLE;
              rx_cnt_d   = '0;
              rx_sub_d   = '0;
            end
          end
          S_DATA:   rx_shift_d = {rx_vote, rx_shift_q[data_bits-1:1]};
          S_PARITY: rx_pbit_d  = rx_vote;
          S_STOP: begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shift_q;
            rx_pe_d    = HAS_PAR && (rx_pbit_q != ((^rx_shift_q) ^ ODD));
            rx_fe_d    = !rx_vote;
            rx_brk_d   = !rx_vote && (rx_shift_q == '0) && !(HAS_PAR && rx_pbit_q);
            rx_state_d = S_IDLE;
            rx_cnt_d   = '0;
            rx_sub_d   = '0;
          end
          default: rx_state_d = S_IDLE;
        endcase
      end
      if (rx_tick && rx_sub_q == 4'd15) begin
        case (rx_state_q)
          S_START: begin
            rx_state_d = S_DATA;
            rx_bit_d   = '0;
          end
          S_DATA: begin
            if (rx_bit_q == LAST_DBIT) rx_state_d = HAS_PAR ? S_PARITY : S_STOP;
            else                       rx_bit_d   = rx_bit_q + 4'd1;
          end
          S_PARITY: rx_state_d = S_STOP;
          default:  rx_state_d = S_IDLE;
        endcase
      end
    end
  end

  // RX state register, synchroniser and output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_sub_q   <= '0;
      rx_bit_q   <= '0;
      rx_smp_q   <= '0;
      rx_shift_q <= '0;
      rx_pbit_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_pe_q    <= 1'b0;
      rx_fe_q    <= 1'b0;
      rx_brk_q   <= 1'b0;
    end else begin
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_sub_q   <= rx_sub_d;
      rx_bit_q   <= rx_bit_d;
      rx_smp_q   <= rx_smp_d;
      rx_shift_q <= rx_shift_d;
      rx_pbit_q  <= rx_pbit_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_pe_q    <= rx_pe_d;
      rx_fe_q    <= rx_fe_d;
      rx_brk_q   <= rx_brk_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_pe_q;
  assign rx_frame_err  = rx_fe_q;
  assign rx_break      = rx_brk_q;

endmodule

// File: tb/tb_uart_phy_ext.sv
// tb_uart_phy_ext: directed checks of uart_phy_ext at 64 clocks per bit.
// d0 = 8N1 (TX trace, reset, bit-banged RX), d1 = 8E1 loopback, d2 = 7O2 RX.
module tb_uart_phy_ext;

  localparam int CLK_HZ = 7372800;
  localparam int BAUD   = 115200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // d0 : 8N1
  logic       d0_tx, d0_rdy, d0_rxv, d0_pe, d0_fe, d0_brk;
  logic [7:0] d0_rxd;
  logic       rx0 = 1'b1;
  logic [7:0] tx_data0 = '0;
  logic       tx_valid0 = 1'b0;
  // d1 : 8E1 loopback
  logic       lb, d1_rdy, d1_rxv, d1_pe, d1_fe, d1_brk;
  logic [7:0] d1_rxd;
  logic [7:0] tx_data1 = '0;
  logic       tx_valid1 = 1'b0;
  // d2 : 7O2
  logic       d2_tx, d2_rdy, d2_rxv, d2_pe, d2_fe, d2_brk;
  logic [6:0] d2_rxd;
  logic       rx2 = 1'b1;
  logic [6:0] tx_data2 = '0;
  logic       tx_valid2 = 1'b0;

  uart_phy_ext #(.clk_hz(CLK_HZ), .baudrate(BAUD), .data_bits(8), .parity_mode(0), .stop_bits(1)) d0 (
    .clk(clk), .rst(rst), .UART_TX(d0_tx), .UART_RX(rx0), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(d0_rdy), .rx_data(d0_rxd), .rx_valid(d0_rxv), .rx_parity_err(d0_pe),
    .rx_frame_err(d0_fe), .rx_break(d0_brk));

  uart_phy_ext #(.clk_hz(CLK_HZ), .baudrate(BAUD), .data_bits(8), .parity_mode(2), .stop_bits(1)) d1 (
    .clk(clk), .rst(rst), .UART_TX(lb), .UART_RX(lb), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(d1_rdy), .rx_data(d1_rxd), .rx_valid(d1_rxv), .rx_parity_err(d1_pe),
    .rx_frame_err(d1_fe), .rx_break(d1_brk));

  uart_phy_ext #(.clk_hz(CLK_HZ), .baudrate(BAUD), .data_bits(7), .parity_mode(1), .stop_bits(2)) d2 (
    .clk(clk), .rst(rst), .UART_TX(d2_tx), .UART_RX(rx2), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(d2_rdy), .rx_data(d2_rxd), .rx_valid(d2_rxv), .rx_parity_err(d2_pe),
    .rx_frame_err(d2_fe), .rx_break(d2_brk));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // receive monitors: capture each rx_valid pulse; flags must be 0 otherwise
  int rcnt0 = 0, rcnt1 = 0, rcnt2 = 0;
  logic [7:0] rd0, rd1;
  logic [6:0] rd2;
  logic rpe0, rfe0, rbk0, rpe1, rfe1, rbk1, rpe2, rfe2, rbk2;

  always @(negedge clk) begin
    if (d0_rxv) begin
      rcnt0++; rd0 = d0_rxd; rpe0 = d0_pe; rfe0 = d0_fe; rbk0 = d0_brk;
    end else if (d0_pe | d0_fe | d0_brk) begin
      bad++; $display("FAIL d0 flags idle: got %b%b%b expected 000", d0_pe, d0_fe, d0_brk);
    end
    if (d1_rxv) begin
      rcnt1++; rd1 = d1_rxd; rpe1 = d1_pe; rfe1 = d1_fe; rbk1 = d1_brk;
    end else if (d1_pe | d1_fe | d1_brk) begin
      bad++; $display("FAIL d1 flags idle: got %b%b%b expected 000", d1_pe, d1_fe, d1_brk);
    end
    if (d2_rxv) begin
      rcnt2++; rd2 = d2_rxd; rpe2 = d2_pe; rfe2 = d2_fe; rbk2 = d2_brk;
    end else if (d2_pe | d2_fe | d2_brk) begin
      bad++; $display("FAIL d2 flags idle: got %b%b%b expected 000", d2_pe, d2_fe, d2_brk);
    end
  end

  // drive a bit-banged line level for nbits bit times (64 clocks each)
  task automatic bang(input int which, input logic v, input int nbits);
    if (which == 0) rx0 = v; else rx2 = v;
    repeat (64*nbits) @(negedge clk);
  endtask

  task automatic send_rx0(input logic [7:0] d, input int stop_low);
    bang(0, 1'b0, 1);
    for (int i = 0; i < 8; i++) bang(0, d[i], 1);
    if (stop_low > 0) bang(0, 1'b0, stop_low);
    bang(0, 1'b1, 3);
  endtask

  task automatic send_rx2(input logic [6:0] d, input logic par);
    bang(2, 1'b0, 1);
    for (int i = 0; i < 7; i++) bang(2, d[i], 1);
    bang(2, par, 1);
    bang(2, 1'b1, 4);
  endtask

  // send one d0 frame and record UART_TX / tx_ready from the cycle after accept
  logic tr_line [0:719];
  logic tr_rdy  [0:719];
  task automatic tx0(input logic [7:0] d);
    @(negedge clk);
    chk("d0 tx_ready before send", d0_rdy, 1);
    tx_data0 = d; tx_valid0 = 1'b1;
    @(negedge clk);
    tx_valid0 = 1'b0;
    for (int k = 0; k < 720; k++) begin
      tr_line[k] = d0_tx;
      tr_rdy[k]  = d0_rdy;
      if (k == 100) begin tx_valid0 = 1'b1; tx_data0 = 8'hFF; end
      if (k == 101) tx_valid0 = 1'b0;
      @(negedge clk);
    end
  endtask

  typedef struct { int bidx; logic exp; } txv_t;
  typedef struct { logic [7:0] data; int stop_low; logic [7:0] exp_data; logic exp_fe; logic exp_brk; } rxv_t;

  initial begin
    txv_t tv [10];
    rxv_t rv [5];
    int lows;
    logic [9:0] fexp;

    // 0xA5 in 8N1: start, LSB-first data, stop
    tv[0] = '{0, 1'b0}; tv[1] = '{1, 1'b1}; tv[2] = '{2, 1'b0}; tv[3] = '{3, 1'b1};
    tv[4] = '{4, 1'b0}; tv[5] = '{5, 1'b0}; tv[6] = '{6, 1'b1}; tv[7] = '{7, 1'b0};
    tv[8] = '{8, 1'b1}; tv[9] = '{9, 1'b1};
    // d0 RX frames: data, stop-low bit times, expected data/frame_err/break
    rv[0] = '{8'h5A, 0, 8'h5A, 1'b0, 1'b0};
    rv[1] = '{8'h00, 0, 8'h00, 1'b0, 1'b0};
    rv[2] = '{8'hFF, 1, 8'hFF, 1'b1, 1'b0};
    rv[3] = '{8'h00, 2, 8'h00, 1'b1, 1'b1};
    rv[4] = '{8'hC3, 0, 8'hC3, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst UART_TX", d0_tx, 1);
    chk("rst tx_ready", d0_rdy, 1);
    chk("rst rx_valid", d0_rxv, 0);
    chk("rst rx_data", d0_rxd, 0);
    chk("rst flags", {d0_pe, d0_fe, d0_brk}, 0);
    chk("rst d1 tx_ready", d1_rdy, 1);
    chk("rst d2 UART_TX", d2_tx, 1);
    chk("rst d2 tx_ready", d2_rdy, 1);

    // 8N1 TX of 0xA5 (with an ignored tx_valid mid-frame)
    tx0(8'hA5);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("A5 bit%0d first", tv[i].bidx), tr_line[64*tv[i].bidx], tv[i].exp);
      chk($sformatf("A5 bit%0d last", tv[i].bidx), tr_line[64*tv[i].bidx + 63], tv[i].exp);
    end
    lows = 0;
    for (int k = 0; k < 720; k++) if (!tr_rdy[k]) lows++;
    chk("A5 tx_ready low cycles", lows, 640);
    chk("A5 tx_ready at 639", tr_rdy[639], 0);
    chk("A5 tx_ready at 640", tr_rdy[640], 1);
    chk("A5 line idle after", tr_line[700], 1);

    // reset at cycle 200 of a frame of 0x00
    @(negedge clk);
    tx_data0 = 8'h00; tx_valid0 = 1'b1;
    @(negedge clk);
    tx_valid0 = 1'b0;
    repeat (199) @(negedge clk);
    chk("pre-rst line", d0_tx, 0);
    chk("pre-rst tx_ready", d0_rdy, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post-rst UART_TX", d0_tx, 1);
    chk("post-rst tx_ready", d0_rdy, 1);
    tx0(8'h3C);
    fexp = {1'b1, 8'h3C, 1'b0};
    for (int i = 0; i < 10; i++) chk($sformatf("3C bit%0d", i), tr_line[64*i + 32], fexp[i]);
    chk("3C tx_ready at 640", tr_rdy[640], 1);

    // 8E1 loopback of 0x37: parity bit (bit 9) must be 1
    @(negedge clk);
    rcnt1 = 0;
    tx_data1 = 8'h37; tx_valid1 = 1'b1;
    @(negedge clk);
    tx_valid1 = 1'b0;
    repeat (608) @(negedge clk);
    chk("8E1 parity bit on line", lb, 1);
    for (int i = 0; i < 300 && rcnt1 == 0; i++) @(negedge clk);
    repeat (100) @(negedge clk);
    chk("8E1 rx_valid count", rcnt1, 1);
    chk("8E1 rx_data", rd1, 8'h37);
    chk("8E1 parity_err", rpe1, 0);
    chk("8E1 frame_err", rfe1, 0);
    chk("8E1 break", rbk1, 0);
    chk("8E1 tx_ready after", d1_rdy, 1);

    // 20-cycle glitch on d0 RX: false start, no output
    rcnt0 = 0;
    rx0 = 1'b0;
    repeat (20) @(negedge clk);
    rx0 = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch no rx_valid", rcnt0, 0);

    // d0 RX table (first entry also shows RX returned to IDLE after glitch)
    for (int i = 0; i < 5; i++) begin
      rcnt0 = 0;
      send_rx0(rv[i].data, rv[i].stop_low);
      chk($sformatf("rx%0d count", i), rcnt0, 1);
      chk($sformatf("rx%0d data", i), rd0, rv[i].exp_data);
      chk($sformatf("rx%0d frame_err", i), rfe0, rv[i].exp_fe);
      chk($sformatf("rx%0d break", i), rbk0, rv[i].exp_brk);
      chk($sformatf("rx%0d parity_err", i), rpe0, 0);
    end

    // 7O2: 0x4B has four ones, odd parity bit is 1; send 0 then 1
    rcnt2 = 0;
    send_rx2(7'h4B, 1'b0);
    chk("7O2 flip count", rcnt2, 1);
    chk("7O2 flip data", rd2, 7'h4B);
    chk("7O2 flip parity_err", rpe2, 1);
    chk("7O2 flip frame_err", rfe2, 0);
    chk("7O2 flip break", rbk2, 0);
    rcnt2 = 0;
    send_rx2(7'h4B, 1'b1);
    chk("7O2 good count", rcnt2, 1);
    chk("7O2 good parity_err", rpe2, 0);
    chk("7O2 good frame_err", rfe2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
